alu_seq: RTL and testbench
==========================

# alu_seq

Pipelined, handshaked ALU for the RISC-V-Reduced datapath. It is the parametrised successor of the combinational ALU: same operand-select and `eq` semantics, plus XOR, shift-left, signed set-less-than and an optional iterative multiplier. Operations enter over a valid/ready handshake and results are returned from a registered output stage. This lets the core stall on multi-cycle operations.

## Interface
Parameters:
- `D_WIDTH`, 32: datapath width. Power of two, ≥ 8.
- `SH_W`, `$clog2(D_WIDTH)`: shift-amount width. Derived; do not override.

Ports:
- `clk`  in  1  clock. All state updates on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  block accepts a request this cycle.
- `alusrc`  in  1  1: operand 2 = `immop`; 0: operand 2 = `regop2`.
- `aluctrl`  in  3  opcode.
- `aluop1`  in  D_WIDTH  operand 1.
- `immop`  in  D_WIDTH  immediate operand.
- `regop2`  in  D_WIDTH  register operand.
- `out_valid`  out  1  result held in the output register.
- `out_ready`  in  1  consumer takes the result.
- `aluout`  out  D_WIDTH  registered result.
- `eq`  out  1  registered `aluop1 == op2`, captured at accept.

## Operation
- Accept: `in_valid && in_ready`. On accept, `aluctrl`, `aluop1` and op2 (selected by `alusrc`) are latched.
- Opcodes:
  - 000 add
  - 001 sub
  - 010 and
  - 011 or
  - 100 xor
  - 101 sll by `op2[SH_W-1:0]`
  - 110 slt (signed; result 1 or 0, zero-extended)
  - 111 mul (low D_WIDTH bits of the product)
- All arithmetic is modulo 2^D_WIDTH. There are no flags other than `eq`.
- FSM states:
  - IDLE: `in_ready` = `!out_valid || out_ready`.
    - Accepting opcodes 000–110: the result is written to `aluout` and `out_valid` is set, staying in IDLE.
    - Accepting 111: go to MUL, with `in_ready` = 0.
  - MUL: radix-2 shift-add, one multiplier bit per cycle, LSB first, with an iteration counter 0..D_WIDTH-1.
    - When the counter reaches D_WIDTH-1: write the product to `aluout`, set `out_valid`, return to IDLE.
- Output register:
  - `out_valid && out_ready` clears `out_valid` unless a new result is written in the same cycle. A new write takes priority: `out_valid` stays 1 and `aluout` updates.
  - While `out_valid && !out_ready`, `aluout` and `eq` hold stable.
- MUL with `out_valid` still set: MUL entry requires `in_ready`, so the previous result has been drained or is draining. The multiplier never overwrites an unconsumed result.
- Inputs are ignored while `in_ready` = 0.

## Timing
- Reset (`rst_n` = 0 at an edge) forces:
  - state IDLE
  - `out_valid` 0, `aluout` 0, `eq` 0
  - counter 0
  - `in_ready` = 0 while `rst_n` = 0, and 1 in the first cycle after release.
- Reset mid-MUL: the operation is aborted and no result is produced.
- Single-cycle ops: accepted at edge N, `out_valid` = 1 after edge N (visible in cycle N+1). Back-to-back throughput is 1 per cycle when `out_ready` = 1.
- MUL: accepted at edge N, `out_valid` = 1 after edge N+D_WIDTH. `in_ready` = 0 for cycles N+1 .. N+D_WIDTH.
- `in_ready` is combinational from state, `out_valid` and `out_ready`. There is no combinational path from `in_valid` to `in_ready`.

## Configuration
- `ALU_SEQ_MUL_EN` defined:
  - MUL state, counter and multiplier are present.
  - Opcode 111 behaves as specified above.
- Not defined:
  - No MUL state or multiplier logic is built.
  - Opcode 111 completes in one cycle with `aluout` = 0, like the other single-cycle ops.
  - `eq` remains valid in both builds.

## Test plan
- Reset and single ops: hold `rst_n` low for 2 cycles, so all outputs read 0. Then, with `out_ready` = 1:
  - add 5 + 7 with `alusrc` = 0 → `aluout` = 12, `eq` = 0, one cycle after accept.
  - sub 3 − 5 → `aluout` = 0xFFFFFFFE.
- Operand select, slt and shift:
  - `alusrc` = 1, `immop` = 0xFFFFFFFF, `aluop1` = 1, slt → `aluout` = 0, `eq` = 0.
  - sll 1 by `regop2` = 33 → `aluout` = 2 (only the low 5 bits are used).
- Backpressure: two xor ops issued with `out_ready` = 0.
  - The first result is held and `in_ready` = 0.
  - Raising `out_ready` drains the first result and accepts the second in the same cycle.
- Multiply (`ALU_SEQ_MUL_EN`): 0x0001_0003 × 0x0000_0005 → `aluout` = 0x0005_000F exactly 32 cycles after accept. `in_ready` stays low throughout.
- Multiply without the macro: the same stimulus gives `aluout` = 0 one cycle after accept.
- Reset mid-MUL: assert `rst_n` = 0 at cycle 10 of a multiply, then release.
  - No `out_valid` pulse appears.
  - A subsequent add 1 + 1 returns 2.

Source files
------------

// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq: operand request handshake in, registered result handshake out.
interface alu_seq_if #(
  parameter int D_WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               alusrc;
  logic [2:0]         aluctrl;
  logic [D_WIDTH-1:0] aluop1;
  logic [D_WIDTH-1:0] immop;
  logic [D_WIDTH-1:0] regop2;
  logic               out_valid;
  logic               out_ready;
  logic [D_WIDTH-1:0] aluout;
  logic               eq;

  modport master (
    output in_valid, alusrc, aluctrl, aluop1, immop, regop2, out_ready,
    input  in_ready, out_valid, aluout, eq
  );

  modport slave (
    input  in_valid, alusrc, aluctrl, aluop1, immop, regop2, out_ready,
    output in_ready, out_valid, aluout, eq
  );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU with a registered result stage; define ALU_SEQ_MUL_EN to build the
// iterative radix-2 multiplier for opcode 111 (otherwise 111 returns 0 in one cycle).
module alu_seq #(
  parameter  int D_WIDTH = 32,
  localparam int SH_W    = $clog2(D_WIDTH)
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  function automatic logic [D_WIDTH-1:0] alu_comb(input logic [2:0]         op,
                                                  input logic [D_WIDTH-1:0] a,
                                                  input logic [D_WIDTH-1:0] b);
    logic signed [D_WIDTH-1:0] sa;
    logic signed [D_WIDTH-1:0] sb;
    logic [D_WIDTH-1:0]        r;
    sa = a;
    sb = b;
    case (op)
      3'b000:  r = a + b;
      3'b001:  r = a - b;
      3'b010:  r = a & b;
      3'b011:  r = a | b;
      3'b100:  r = a ^ b;
      3'b101:  r = a << b[SH_W-1:0];
      3'b110:  r = {{(D_WIDTH-1){1'b0}}, (sa < sb)};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [D_WIDTH-1:0] op2;
  logic               accept;
  logic               rdy;
  logic               wr_en;
  logic [D_WIDTH-1:0] wr_data;
  logic               vld_p1;
  logic [D_WIDTH-1:0] res_p1;
  logic               eq_p1;

  assign op2    = bus.alusrc ? bus.immop : bus.regop2;
  assign accept = bus.in_valid && rdy;

`ifdef ALU_SEQ_MUL_EN
  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  localparam logic [SH_W-1:0] CNT_LAST = SH_W'(D_WIDTH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [SH_W-1:0]    cnt_p1;
  logic [D_WIDTH-1:0] mcand_p1;
  logic [D_WIDTH-1:0] mplier_p1;
  logic [D_WIDTH-1:0] prod_p1;
  logic [D_WIDTH-1:0] prod_sum;

  assign prod_sum = prod_p1 + (mplier_p1[0] ? mcand_p1 : '0);

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state)
      IDLE: begin
        rdy = rst_n && (!vld_p1 || bus.out_ready);
        if (bus.in_valid && rdy) begin
          if (bus.aluctrl == 3'b111) begin
            state_nxt = MUL;
          end else begin
            wr_en   = 1'b1;
            wr_data = alu_comb(bus.aluctrl, bus.aluop1, op2);
          end
        end
      end
      MUL: begin
        if (cnt_p1 == CNT_LAST) begin
          state_nxt = IDLE;
          wr_en     = 1'b1;
          wr_data   = prod_sum;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt_p1 <= '0;
    end else begin
      state <= state_nxt;
      if (state == MUL) cnt_p1 <= (cnt_p1 == CNT_LAST) ? '0 : cnt_p1 + SH_W'(1);
      else              cnt_p1 <= '0;
    end
  end

  // Multiplier datapath: multiplicand shifts up, multiplier shifts down, LSB first.
  always_ff @(posedge clk) begin
    if (accept) begin
      mcand_p1  <= bus.aluop1;
      mplier_p1 <= op2;
      prod_p1   <= '0;
    end else if (state == MUL) begin
      prod_p1   <= prod_sum;
      mcand_p1  <= mcand_p1 << 1;
      mplier_p1 <= mplier_p1 >> 1;
    end
  end
`else
  always_comb begin
    rdy     = rst_n && (!vld_p1 || bus.out_ready);
    wr_en   = bus.in_valid && rdy;
    wr_data = alu_comb(bus.aluctrl, bus.aluop1, op2);
  end
`endif

  // Output stage: a fresh write wins over a drain in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
      eq_p1  <= 1'b0;
    end else begin
      if (wr_en) begin
        vld_p1 <= 1'b1;
        res_p1 <= wr_data;
      end else if (vld_p1 && bus.out_ready) begin
        vld_p1 <= 1'b0;
      end
      if (accept) eq_p1 <= (bus.aluop1 == op2);
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld_p1;
  assign bus.aluout    = res_p1;
  assign bus.eq        = eq_p1;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: reset, each opcode, operand select, backpressure, multiply and reset abort.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  logic flag;

  alu_seq_if #(.D_WIDTH(32)) bus ();

  alu_seq #(.D_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for a single edge, then withdraw it.
  task automatic issue(input logic [2:0] ctrl, input logic src, input logic [31:0] a,
                       input logic [31:0] imm, input logic [31:0] r);
    bus.in_valid = 1'b1;
    bus.aluctrl  = ctrl;
    bus.alusrc   = src;
    bus.aluop1   = a;
    bus.immop    = imm;
    bus.regop2   = r;
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_pass        = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.alusrc    = 1'b0;
    bus.aluctrl   = 3'b000;
    bus.aluop1    = '0;
    bus.immop     = '0;
    bus.regop2    = '0;
    bus.out_ready = 1'b1;

    tick();
    tick();
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_aluout",    bus.aluout,             32'd0);
    check("rst_eq",        {31'd0, bus.eq},        32'd0);

    rst_n = 1'b1;
    #1;
    check("rel_in_ready", {31'd0, bus.in_ready}, 32'd1);

    issue(3'b000, 1'b0, 32'd5, 32'd0, 32'd7);
    check("add_valid", {31'd0, bus.out_valid}, 32'd1);
    check("add_out",   bus.aluout,             32'd12);
    check("add_eq",    {31'd0, bus.eq},        32'd0);

    issue(3'b001, 1'b0, 32'd3, 32'd0, 32'd5);
    check("sub_valid", {31'd0, bus.out_valid}, 32'd1);
    check("sub_out",   bus.aluout,             32'hFFFF_FFFE);

    issue(3'b110, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd1);
    check("slt_imm_out", bus.aluout,      32'd0);
    check("slt_imm_eq",  {31'd0, bus.eq}, 32'd0);

    issue(3'b110, 1'b0, 32'hFFFF_FFFF, 32'd0, 32'd1);
    check("slt_neg_out", bus.aluout, 32'd1);

    issue(3'b010, 1'b0, 32'h0000_F0F0, 32'd0, 32'h0000_F0F0);
    check("and_out", bus.aluout,      32'h0000_F0F0);
    check("and_eq",  {31'd0, bus.eq}, 32'd1);

    issue(3'b011, 1'b0, 32'h0000_0F00, 32'd0, 32'h0000_00F0);
    check("or_out", bus.aluout, 32'h0000_0FF0);

    issue(3'b101, 1'b0, 32'd1, 32'd0, 32'd33);
    check("sll_out", bus.aluout, 32'd2);

    tick();
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);

    bus.out_ready = 1'b0;
    issue(3'b100, 1'b0, 32'h0000_FF00, 32'd0, 32'h0000_0FF0);
    check("bp_first_out",   bus.aluout,             32'h0000_F0F0);
    check("bp_in_ready_lo", {31'd0, bus.in_ready},  32'd0);
    bus.in_valid = 1'b1;
    bus.aluctrl  = 3'b100;
    bus.aluop1   = 32'h0000_AAAA;
    bus.regop2   = 32'h0000_5555;
    tick();
    check("bp_hold_out",   bus.aluout,             32'h0000_F0F0);
    check("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    #1;
    check("bp_in_ready_hi", {31'd0, bus.in_ready}, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("bp_second_out",   bus.aluout,             32'h0000_FFFF);
    check("bp_second_valid", {31'd0, bus.out_valid}, 32'd1);
    tick();
    check("bp_drain_valid", {31'd0, bus.out_valid}, 32'd0);

`ifdef ALU_SEQ_MUL_EN
    issue(3'b111, 1'b0, 32'h0001_0003, 32'd0, 32'd5);
    flag = bus.in_ready | bus.out_valid;
    for (int k = 1; k < 32; k++) begin
      tick();
      flag = flag | bus.in_ready | bus.out_valid;
    end
    check("mul_busy", {31'd0, flag}, 32'd0);
    tick();
    check("mul_valid",    {31'd0, bus.out_valid}, 32'd1);
    check("mul_out",      bus.aluout,             32'h0005_000F);
    check("mul_eq",       {31'd0, bus.eq},        32'd0);
    check("mul_in_ready", {31'd0, bus.in_ready},  32'd1);
    tick();

    issue(3'b111, 1'b0, 32'h0001_0003, 32'd0, 32'd5);
    for (int k = 1; k < 10; k++) tick();
`else
    issue(3'b111, 1'b0, 32'h0001_0003, 32'd0, 32'd5);
    check("mul_off_valid", {31'd0, bus.out_valid}, 32'd1);
    check("mul_off_out",   bus.aluout,             32'd0);
    check("mul_off_eq",    {31'd0, bus.eq},        32'd0);
    tick();
`endif

    rst_n = 1'b0;
    tick();
    check("abort_rst_valid",  {31'd0, bus.out_valid}, 32'd0);
    check("abort_rst_aluout", bus.aluout,             32'd0);
    rst_n = 1'b1;
    flag = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      flag = flag | bus.out_valid;
    end
    check("abort_no_pulse", {31'd0, flag}, 32'd0);

    issue(3'b000, 1'b0, 32'd1, 32'd0, 32'd1);
    check("post_add_valid", {31'd0, bus.out_valid}, 32'd1);
    check("post_add_out",   bus.aluout,             32'd2);
    check("post_add_eq",    {31'd0, bus.eq},        32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
